// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared fetch-sequencer constants: FSM state encodings, NOP word, PC step.
// Pure definitions, no logic.
package pc_fetch_sequencer_pkg;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE    = 3'd0;
    localparam fetch_state_t ST_REQ     = 3'd1;
    localparam fetch_state_t ST_WAIT    = 3'd2;
    localparam fetch_state_t ST_PRESENT = 3'd3;
    localparam fetch_state_t ST_FAULT   = 3'd4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_sel.sv
// Next-PC select: jump > branch > sequential, with misalignment flag.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is used.
module pc_next_sel
    import pc_fetch_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;

    // Plain 32-bit add: the carry out is dropped, so 0xFFFF_FFFC wraps to 0.
    assign seq_pc = pc + PC_INCR;

    always_comb begin
        next_pc = seq_pc;
        if (jump_valid) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    assign misaligned = is_misaligned(next_pc);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: request, wait for data, present, redirect.
// Fetch-to-fetch 3 cycles minimum; holds req/addr until imem_ready, holds instr while stall.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        fault,
    output logic [31:0] retired_count
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  next_pc;
    logic         next_misaligned;

    pc_next_sel u_pc_next_sel (
        .pc            (pc_out),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .misaligned    (next_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            fetch_pc      <= RESET_VECTOR;
            instr         <= NOP_INSTR;
            pc_out        <= RESET_VECTOR;
            retired_count <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    fetch_pc <= RESET_VECTOR;
                    state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        state <= ST_WAIT;
                    end
                end
                // Read data is only sampled here, so stray or pre-reset responses are dropped.
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr  <= imem_rdata;
                        pc_out <= fetch_pc;
                        state  <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (!stall) begin
                        retired_count <= retired_count + 32'd1;
                        fetch_pc      <= next_pc;
                        state         <= next_misaligned ? ST_FAULT : ST_REQ;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = fetch_pc;
    assign instr_valid = (state == ST_PRESENT);
    assign fault       = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: memory model plus scoreboard of fetch addresses and responses.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        fault;
    logic [31:0] retired_count;

    pc_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .reset         (reset),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc_out        (pc_out),
        .fault         (fault),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_resp_q[$];
    logic [31:0] exp_retired;
    logic        exp_fault;
    int          consumed = 0;
    logic        plan_jv, plan_bt;
    logic [31:0] plan_jt, plan_btg;
    int          stall_cycles, ready_hold;
    logic        req_held;
    logic [31:0] held_addr;
    logic        will_accept;
    logic [31:0] acc_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},     32'(imem_req), 32'd0);
        chk({tag, "_addr"},    imem_addr, RV);
        chk({tag, "_valid"},   32'(instr_valid), 32'd0);
        chk({tag, "_instr"},   instr, 32'h0000_0013);
        chk({tag, "_pc"},      pc_out, RV);
        chk({tag, "_fault"},   32'(fault), 32'd0);
        chk({tag, "_retired"}, retired_count, 32'd0);
    endtask

    task automatic model_reset();
        exp_addr_q.delete();
        exp_resp_q.delete();
        exp_addr_q.push_back(RV);
        exp_retired  = 32'd0;
        exp_fault    = 1'b0;
        plan_jv      = 1'b0;
        plan_bt      = 1'b0;
        plan_jt      = 32'd0;
        plan_btg     = 32'd0;
        stall_cycles = 0;
        ready_hold   = 0;
        req_held     = 1'b0;
    endtask

    // One clock: called and returning at a falling edge.
    task automatic tick();
        logic        consume;
        logic [31:0] nxt;
        logic [63:0] r;
        chk("retired", retired_count, exp_retired);
        chk("fault", 32'(fault), 32'(exp_fault));
        if (exp_fault) begin
            chk("fault_req", 32'(imem_req), 32'd0);
            chk("fault_valid", 32'(instr_valid), 32'd0);
        end
        if (req_held) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, held_addr);
        end

        stall   = 1'b0;
        consume = 1'b0;
        r       = 64'd0;
        if (instr_valid) begin
            if (stall_cycles > 0) begin
                stall = 1'b1;
                stall_cycles--;
            end else begin
                consume = 1'b1;
            end
            chk("present_req", 32'(imem_req), 32'd0);
            if (exp_resp_q.size() == 0) begin
                chk("resp_missing", 32'd1, 32'd0);
            end else begin
                r = exp_resp_q[0];
                chk("instr", instr, r[31:0]);
                chk("pc_out", pc_out, r[63:32]);
            end
        end

        if (consume) begin
            if (exp_resp_q.size() != 0) void'(exp_resp_q.pop_front());
            jump_valid    = plan_jv;
            jump_target   = plan_jt;
            branch_taken  = plan_bt;
            branch_target = plan_btg;
            nxt = plan_jv ? plan_jt : (plan_bt ? plan_btg : r[63:32] + 32'd4);
            exp_retired = exp_retired + 32'd1;
            consumed++;
            if (nxt[1:0] != 2'b00) exp_fault = 1'b1;
            else exp_addr_q.push_back(nxt);
            plan_jv = 1'b0;
            plan_bt = 1'b0;
        end else begin
            // Redirect noise outside consume cycles must have no effect.
            jump_valid    = 1'($urandom_range(0, 1));
            jump_target   = $urandom;
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = $urandom;
        end

        imem_ready = 1'b1;
        if (imem_req && ready_hold > 0) begin
            imem_ready = 1'b0;
            ready_hold--;
        end
        req_held    = imem_req && !imem_ready;
        held_addr   = imem_addr;
        will_accept = imem_req && imem_ready;
        acc_addr    = imem_addr;
        if (will_accept) begin
            if (exp_addr_q.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
            else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
            exp_resp_q.push_back({imem_addr, mem_word(imem_addr)});
        end

        @(posedge clk);
        @(negedge clk);
        imem_rvalid = will_accept;
        imem_rdata  = will_accept ? mem_word(acc_addr) : $urandom;
    endtask

    task automatic run_consumes(input string tag, input int n);
        int target;
        int budget;
        target = consumed + n;
        budget = 40 * n + 20;
        while (consumed < target && budget > 0) begin
            tick();
            budget--;
        end
        chk(tag, 32'(consumed), 32'(target));
    endtask

    initial begin
        reset         = 1'b1;
        jump_valid    = 1'b0;
        jump_target   = 32'd0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        stall         = 1'b0;
        imem_ready    = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        reset = 1'b0;

        run_consumes("seq3", 3);
        chk("retired3", retired_count, 32'd3);
        run_consumes("seq_c", 1);

        stall_cycles = 4;
        run_consumes("stall_0x10", 1);

        plan_jv = 1'b1; plan_jt = 32'h0040_0008; plan_bt = 1'b1; plan_btg = 32'h0000_000C;
        run_consumes("jump_over_branch", 1);

        plan_jv = 1'b1; plan_jt = 32'hFFFF_FFFC; ready_hold = 3;
        run_consumes("ready_hold", 1);
        run_consumes("wrap", 1);

        plan_bt = 1'b1; plan_btg = 32'h0000_0006;
        run_consumes("misaligned", 1);
        for (int i = 0; i < 6; i++) tick();
        chk("fault_sticky", 32'(fault), 32'd1);

        reset = 1'b1;
        #1;
        check_reset_outputs("rst_fault");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_consumes("after_fault", 2);

        begin
            int budget = 20;
            will_accept = 1'b0;
            while (!will_accept && budget > 0) begin
                tick();
                budget--;
            end
            chk("reach_wait", 32'(will_accept), 32'd1);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        model_reset();
        @(negedge clk);
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        run_consumes("after_wait_reset", 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
